// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the writeback arbiter and its producers, decode and the
// register file write port.
interface regfile_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            mem_valid;
  logic [AW-1:0]   mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic [AW-1:0]   query_rs1;
  logic [AW-1:0]   query_rs2;
  logic            rs1_busy;
  logic            rs2_busy;
  logic            regwrite;
  logic [AW-1:0]   write_reg;
  logic [XLEN-1:0] write_data;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd, query_rs1, query_rs2,
    input  alu_ready, mem_ready, rs1_busy, rs2_busy,
           regwrite, write_reg, write_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
           issue_valid, issue_rd, query_rs1, query_rs2,
    output alu_ready, mem_ready, rs1_busy, rs2_busy,
           regwrite, write_reg, write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the register file write port, with a
// pending-load scoreboard feeding decode hazard detection.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic                clock,
  input  logic                reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int NREG = 1 << AW;
  localparam logic [AW-1:0]   X0  = {AW{1'b0}};
  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic            prio_q, prio_d;
  logic            alu_gnt_s, mem_gnt_s;
  logic            regwrite_q, regwrite_d;
  logic [AW-1:0]   write_reg_q, write_reg_d;
  logic [XLEN-1:0] write_data_q, write_data_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic [NREG-1:0] mem_clr_s, issue_set_s;

  // Grant decode: readies are held low for the whole of reset.
  always_comb begin
    alu_gnt_s = 1'b0;
    mem_gnt_s = 1'b0;
    if (reset) begin
      alu_gnt_s = 1'b0;
      mem_gnt_s = 1'b0;
    end else begin
      case ({bus.alu_valid, bus.mem_valid})
        2'b10:   alu_gnt_s = 1'b1;
        2'b01:   mem_gnt_s = 1'b1;
        2'b11: begin
          alu_gnt_s = ~prio_q;
          mem_gnt_s = prio_q;
        end
        default: begin
          alu_gnt_s = 1'b0;
          mem_gnt_s = 1'b0;
        end
      endcase
    end
  end

  // A new load to the same rd must survive the retiring one, so set wins.
  assign mem_clr_s   = mem_gnt_s ? (ONE << bus.mem_rd) : {NREG{1'b0}};
  assign issue_set_s = (bus.issue_valid && (bus.issue_rd != X0)) ?
                       (ONE << bus.issue_rd) : {NREG{1'b0}};

  // Next-state for pointer, write stage and scoreboard.
  always_comb begin
    prio_d       = prio_q;
    regwrite_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (alu_gnt_s) begin
      prio_d       = 1'b1;
      regwrite_d   = (bus.alu_rd != X0);
      write_reg_d  = bus.alu_rd;
      write_data_d = bus.alu_data;
    end else if (mem_gnt_s) begin
      prio_d       = 1'b0;
      regwrite_d   = (bus.mem_rd != X0);
      write_reg_d  = bus.mem_rd;
      write_data_d = bus.mem_data;
    end else begin
      prio_d       = prio_q;
      regwrite_d   = 1'b0;
    end
    pending_d = ((pending_q & ~mem_clr_s) | issue_set_s) & ~ONE;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prio_q       <= 1'b0;
      regwrite_q   <= 1'b0;
      write_reg_q  <= {AW{1'b0}};
      write_data_q <= {XLEN{1'b0}};
      pending_q    <= {NREG{1'b0}};
    end else begin
      prio_q       <= prio_d;
      regwrite_q   <= regwrite_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      pending_q    <= pending_d;
    end
  end

  assign bus.alu_ready  = alu_gnt_s;
  assign bus.mem_ready  = mem_gnt_s;
  assign bus.regwrite   = regwrite_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;

  // The write-stage term covers the cycle before the register file is updated.
  assign bus.rs1_busy = pending_q[bus.query_rs1] |
                        (regwrite_q && (write_reg_q == bus.query_rs1) && (bus.query_rs1 != X0));
  assign bus.rs2_busy = pending_q[bus.query_rs2] |
                        (regwrite_q && (write_reg_q == bus.query_rs2) && (bus.query_rs2 != X0));
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Writeback controller for the CPU register file. It shares the register file's single write port between two result producers: the single-cycle ALU path and the multi-cycle load/memory path. It drives the write port from a registered stage and keeps a pending-destination scoreboard so that decode can detect read-after-write hazards on outstanding loads.

## Interface

- XLEN, 32, data width of write data.
- AW, 5, register index width (32 architectural registers).

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- alu_valid  in  1  ALU result available.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- alu_ready  out  1  ALU result accepted this cycle (combinational).
- mem_valid  in  1  load result available.
- mem_rd  in  AW  load destination register.
- mem_data  in  XLEN  load result.
- mem_ready  out  1  load result accepted this cycle (combinational).
- issue_valid  in  1  a load is issued this cycle; marks issue_rd pending.
- issue_rd  in  AW  destination of the issued load.
- query_rs1, query_rs2  in  AW  source registers being decoded.
- rs1_busy, rs2_busy  out  1  source has an outstanding or in-flight write (combinational).
- regwrite  out  1  register file write enable (registered).
- write_reg  out  AW  register file write index (registered).
- write_data  out  XLEN  register file write data (registered).

## Operation

- **Acceptance:** a requester is accepted when its valid and ready are both high.
- **Write limit:** at most one acceptance per cycle.
- **Arbitration:** round-robin with a 1-bit priority pointer `prio` (0 = ALU, 1 = MEM).
  - Only one requester valid: that requester is granted.
  - Both valid: the `prio` side is granted.
  - After any grant, `prio` points to the non-granted side.
  - No grant: `prio` holds.
- **Ready outputs:** `alu_ready` and `mem_ready` are pure grant decodes from the current valids and `prio`. They never depend on readies.
- **Write stage:**
  - On an accepted result, the next edge loads `write_reg`/`write_data` from that requester.
  - `regwrite` is set to 1 if rd != 0, and to 0 if rd == 0. Writes to x0 are accepted and dropped.
  - No acceptance: `regwrite` goes to 0; `write_reg`/`write_data` hold.
- **Scoreboard:** 32-bit `pending` mask.
  - `issue_valid` with `issue_rd` != 0 sets `pending[issue_rd]` at the edge.
  - An accepted MEM result clears `pending[mem_rd]` at the edge.
  - Set and clear of the same index in the same cycle: set wins (a new load to the same rd).
  - `pending[0]` is always 0.
- **Busy outputs:** `rsN_busy` = `pending[query_rsN]` OR (`regwrite` AND `write_reg` == `query_rsN` AND `query_rsN` != 0). The second term covers the write-stage cycle, before the register file has been updated.
- **ALU results** never touch the scoreboard.

## Timing

- **Reset values:** `regwrite`=0, `write_reg`=0, `write_data`=0, `pending`=0, `prio`=0 (ALU first).
- **Ready outputs during reset:** `alu_ready`/`mem_ready` are 0 while reset is high, regardless of valids.
- **Latency:** acceptance in cycle N; `regwrite` high in cycle N+1; the register file holds the value after the edge ending cycle N+1.
- **Throughput:** one write per cycle sustained. With both sides continuously valid, grants alternate ALU, MEM, ALU, ...
- **Holding requesters:** a requester not granted must hold valid/rd/data stable; the arbiter does not buffer it.
- **Busy window:** for a load issued in cycle N, `busy` is high from cycle N+1 through the cycle its result is in the write stage, and low the following cycle.
- **Reset mid-operation:**
  - Asserting reset clears `pending` and any in-flight write immediately (asynchronously).
  - A result that was valid at that moment is not written.

## Test plan

- **Reset:** assert reset with both valids high -> `regwrite`=0, both readies 0, `rs1_busy`=0 for all queries; release -> first both-valid cycle grants ALU.
- **Contention:** `alu_valid`=`mem_valid`=1 for 4 cycles (`alu_rd`=3, `mem_rd`=4) -> `regwrite` on cycles 2-5 with `write_reg` = 3, 4, 3, 4.
- **Load hazard:** `issue_valid` with `issue_rd`=7 in cycle 1, `query_rs1`=7 -> `rs1_busy`=1 from cycle 2. MEM result `rd`=7, `data`=0xDEADBEEF accepted in cycle 5 -> `busy` stays 1 through cycle 6 (`regwrite`, `write_reg`=7, `write_data`=0xDEADBEEF), then 0 in cycle 7.
- **x0 write:** accepted ALU result with `rd`=0, `data`=0x12345678 -> `alu_ready`=1, `regwrite` stays 0; `issue_rd`=0 -> `pending` unchanged, `rs1_busy`=0 for `query_rs1`=0.
- **Same-cycle set and clear:** MEM result `rd`=9 accepted while `issue_valid` with `issue_rd`=9 -> `pending[9]` remains 1 after the edge.
- **Reset mid-operation:** assert reset in the cycle after acceptance -> `regwrite` drops to 0 immediately and `pending` is all zero.
